// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and decode helpers for the byte-sequential load/store unit.
//   lsu_op_t     : request operation encoding driven by EX on req_op
//   lsu_state_t  : sequencer states
//   op_size      : number of bytes moved by an op (0 for NONE/illegal)
//   op_is_signed : load result is sign-extended
//   op_is_store  : op writes memory
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_LWU  = 4'd6,
    OP_LD   = 4'd7,
    OP_SB   = 4'd8,
    OP_SH   = 4'd9,
    OP_SW   = 4'd10,
    OP_SD   = 4'd11
  } lsu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] op_size(input lsu_op_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = 4'd1;
      OP_LH, OP_LHU, OP_SH: op_size = 4'd2;
      OP_LW, OP_LWU, OP_SW: op_size = 4'd4;
      OP_LD, OP_SD:         op_size = 4'd8;
      default:              op_size = 4'd0;
    endcase
  endfunction

  function automatic logic op_is_signed(input lsu_op_t op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LD: op_is_signed = 1'b1;
      default:                    op_is_signed = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input lsu_op_t op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SD: op_is_store = 1'b1;
      default:                    op_is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// -----------------------------------------------------------------------------
// lsu_extend
// Combinational sign/zero extension of little-endian assembled load bytes.
// Kept separate so a future cache path can reuse it.
//   data_i   : assembled bytes, byte 0 in bits [7:0]
//   size_i   : number of valid bytes (1/2/4/8)
//   signed_i : 1 = sign-extend, 0 = zero-extend
//   result_o : XLEN-wide extended value
// -----------------------------------------------------------------------------
module lsu_extend #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [3:0]      size_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] result_o
);

  logic       sign_bit;
  logic [6:0] width_bits;

  assign width_bits = {size_i, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    case (size_i)
      4'd1: sign_bit = data_i[7];
      4'd2: sign_bit = data_i[15];
      4'd4: sign_bit = data_i[31];
      default: sign_bit = 1'b0;
    endcase
    sign_bit = sign_bit & signed_i;
  end

  // Bits inside the access width pass through; everything above is the fill.
  // A full-width access (4 on RV32, 8 on RV64) therefore comes out raw.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
      assign result_o[gi] = (7'(gi) < width_bits) ? data_i[gi] : sign_bit;
    end
  endgenerate

endmodule

// File: rtl/lsu_byte_seq.sv
// -----------------------------------------------------------------------------
// lsu_byte_seq
// Sequential load/store unit: performs byte/half/word(/double) accesses as a
// run of single-byte transfers on an 8-bit RAM port with RAM_LAT read latency.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      EX handshake (ready only while idle)
//   req_op/addr/wdata/...    request fields, latched on accept
//   ram_ce/we/addr/wdata     byte RAM command port (all zero when idle)
//   ram_rdata                read byte, RAM_LAT cycles after the read issue
//   resp_valid/rd/wreg/data  one-cycle result pulse to WB
//   stall_o                  req_valid && !req_ready
//   err_o                    misalignment trap pulse
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned multi-byte
// accesses instead of performing them byte-wise; otherwise err_o is tied 0.
// -----------------------------------------------------------------------------
module lsu_byte_seq
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN-1:0]   req_result,
  input  logic [4:0]        req_rd,
  input  logic              req_wreg,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic              resp_wreg,
  output logic [XLEN-1:0]   resp_data,
  output logic              stall_o,
  output logic              err_o
);

  localparam int NBYTES = XLEN / 8;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t        state_q, state_d;
  lsu_op_t           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, result_q;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic [4:0]        rd_q;
  logic              wreg_q, err_q;
  logic [3:0]        n_q, i_q, i_d, j_q, j_d;

  // One bit per read in flight; bit RAM_LAT-1 marks the cycle its data arrives.
  logic [RAM_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [RAM_LAT:0]   rd_pipe_ext;

  lsu_op_t         req_op_e, acc_op;
  logic [3:0]      acc_size;
  logic            acc_err, accept, is_store_q, issue_rd, cap_en;
  logic [XLEN-1:0] ext_data;

  // Decode the incoming request. Illegal encodings, and LD/SD on RV32,
  // collapse to NONE so they simply forward req_result.
  always_comb begin
    req_op_e = OP_NONE;
    if (req_op <= 4'd11) req_op_e = lsu_op_t'(req_op);
    acc_size = op_size(req_op_e);
    if (XLEN < 64 && acc_size == 4'd8) acc_size = 4'd0;
    acc_op = (acc_size == 4'd0) ? OP_NONE : req_op_e;
    // size-1 as a low-address mask; for size 8 the 3-bit wrap gives 3'b111.
    acc_err = TRAP_EN && (acc_size > 4'd1) &&
              ((req_addr[2:0] & (acc_size[2:0] - 3'd1)) != 3'd0);
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign accept      = req_valid && req_ready;
  assign stall_o     = req_valid && !req_ready;
  assign is_store_q  = op_is_store(op_q);
  assign issue_rd    = (state_q == ST_ISSUE) && !is_store_q;
  assign rd_pipe_ext = {rd_pipe_q, issue_rd};
  assign rd_pipe_d   = rd_pipe_ext[RAM_LAT-1:0];
  assign cap_en      = rd_pipe_q[RAM_LAT-1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign err_o = (state_q == ST_RESP) && err_q;
`else
  assign err_o = 1'b0;
`endif

  lsu_extend #(.XLEN(XLEN)) u_extend (
    .data_i   (asm_q),
    .size_i   (n_q),
    .signed_i (op_is_signed(op_q)),
    .result_o (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    asm_d      = asm_q;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    resp_valid = 1'b0;
    resp_rd    = '0;
    resp_wreg  = 1'b0;
    resp_data  = '0;

    // Read capture is independent of state: it overlaps ISSUE and DRAIN.
    if (cap_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (j_q == 4'(k)) asm_d[8*k +: 8] = ram_rdata;
      end
      j_d = j_q + 4'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          i_d   = '0;
          j_d   = '0;
          asm_d = '0;
          if (acc_op == OP_NONE || acc_err) state_d = ST_RESP;
          else                              state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ram_ce   = 1'b1;
        ram_we   = is_store_q;
        ram_addr = addr_q + ADDR_W'(i_q);
        if (is_store_q) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (i_q == 4'(k)) ram_wdata = wdata_q[8*k +: 8];
          end
        end
        i_d = i_q + 4'd1;
        if (i_q == n_q - 4'd1) state_d = is_store_q ? ST_RESP : ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave as the last byte lands so RESP sees the completed assembly.
        if (cap_en && j_q == n_q - 4'd1) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rd    = rd_q;
        if (!(err_q || is_store_q)) begin
          resp_wreg = wreg_q;
          resp_data = (op_q == OP_NONE) ? result_q : ext_data;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      wreg_q    <= 1'b0;
      err_q     <= 1'b0;
      n_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      asm_q     <= '0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      asm_q     <= asm_d;
      rd_pipe_q <= rd_pipe_d;
      if (accept) begin
        op_q     <= acc_op;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        result_q <= req_result;
        rd_q     <= req_rd;
        wreg_q   <= req_wreg;
        n_q      <= acc_size;
        err_q    <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
`timescale 1ns/1ps
module tb_lsu_byte_seq;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int RAM_LAT = 1;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk, rst;
  logic              req_valid, req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata, req_result;
  logic [4:0]        req_rd;
  logic              req_wreg;
  logic              ram_ce, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata, ram_rdata;
  logic              resp_valid;
  logic [4:0]        resp_rd;
  logic              resp_wreg;
  logic [XLEN-1:0]   resp_data;
  logic              stall_o, err_o;

  lsu_byte_seq #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_result(req_result),
    .req_rd(req_rd), .req_wreg(req_wreg),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_wreg(resp_wreg),
    .resp_data(resp_data), .stall_o(stall_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // ---------------- RAM environment (1 KB, aliased) ----------------
  function automatic logic [7:0] init_byte(input logic [9:0] idx);
    return idx[7:0] ^ {6'b0, idx[9:8]} ^ 8'hA5;
  endfunction

  logic [7:0] ram_mem [1024];
  bit         ram_written [1024];
  logic [7:0] rd_line [RAM_LAT];
  logic       poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [7:0] poke_data = '0;

  function automatic logic [7:0] ram_get(input logic [31:0] a);
    return ram_written[a[9:0]] ? ram_mem[a[9:0]] : init_byte(a[9:0]);
  endfunction

  always @(posedge clk) begin
    // Garbage on the data bus when no read is due exposes mistimed capture.
    if (ram_ce && !ram_we) rd_line[0] <= ram_get(ram_addr);
    else                   rd_line[0] <= 8'($urandom);
    for (int k = 1; k < RAM_LAT; k++) rd_line[k] <= rd_line[k-1];
    if (ram_ce && ram_we) begin
      ram_mem[ram_addr[9:0]]     <= ram_wdata;
      ram_written[ram_addr[9:0]] <= 1'b1;
    end else if (poke_en) begin
      ram_mem[poke_addr]     <= poke_data;
      ram_written[poke_addr] <= 1'b1;
    end
  end
  assign ram_rdata = rd_line[RAM_LAT-1];

  // ---------------- reference model state ----------------
  logic [7:0] ref_mem [1024];

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } ram_exp_t;

  typedef struct {
    int            cyc;
    logic [4:0]    rd;
    logic          wreg;
    logic [XLEN-1:0] data;
    logic          err;
  } resp_exp_t;

  ram_exp_t  ram_q[$];
  resp_exp_t resp_q[$];
  int busy_from = 0;
  int busy_to   = -1;
  bit mon_en    = 1'b0;

  function automatic int model_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd8:  return 1;
      4'd3, 4'd4, 4'd9:  return 2;
      4'd5, 4'd6, 4'd10: return 4;
      4'd7, 4'd11:       return (XLEN == 64) ? 8 : 0;
      default:           return 0;
    endcase
  endfunction

  // Builds every expectation for a request accepted in cycle acc.
  task automatic model_request(input int acc, input logic [3:0] op, input logic [31:0] addr,
                               input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] result,
                               input logic [4:0] rd, input logic wreg);
    int n, lat;
    bit is_store, is_signed, err;
    logic [63:0] val;
    logic [31:0] a;
    resp_exp_t r;
    n         = model_size(op);
    is_store  = (op >= 4'd8) && (n > 0);
    is_signed = (op == 4'd1) || (op == 4'd3) || (op == 4'd5) || (op == 4'd7);
    err       = TRAP && (n > 1) && ((addr % n) != 0);
    r.rd = rd;
    r.err = 1'b0;
    if (n == 0) begin
      lat = 1; r.wreg = wreg; r.data = result;
    end else if (err) begin
      lat = 1; r.wreg = 1'b0; r.data = '0; r.err = 1'b1;
    end else if (is_store) begin
      lat = n + 1; r.wreg = 1'b0; r.data = '0;
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        ram_q.push_back('{acc + 1 + k, 1'b1, a, 8'(wdata >> (8 * k))});
        ref_mem[a[9:0]] = 8'(wdata >> (8 * k));
      end
    end else begin
      lat = n + RAM_LAT + 1; r.wreg = wreg;
      val = '0;
      for (int k = 0; k < n; k++) begin
        a = addr + 32'(k);
        ram_q.push_back('{acc + 1 + k, 1'b0, a, 8'h00});
        val = val | (64'(ref_mem[a[9:0]]) << (8 * k));
      end
      if (is_signed && n < 8 && val[8*n-1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      r.data = val[XLEN-1:0];
    end
    r.cyc = acc + lat;
    resp_q.push_back(r);
    busy_from = acc;
    busy_to   = acc + lat;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    ram_exp_t  e;
    resp_exp_t r;
    logic      exp_ready;
    wait (mon_en);
    forever begin
      @(negedge clk);
      #1;
      exp_ready = !(cyc > busy_from && cyc <= busy_to);
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("stall_o", 64'(stall_o), 64'(req_valid && !exp_ready));

      if (ram_ce) begin
        if (ram_q.size() == 0) begin
          fail_now("ram_unexpected_access");
        end else begin
          e = ram_q.pop_front();
          check("ram_cycle", 64'(cyc), 64'(e.cyc));
          check("ram_we", 64'(ram_we), 64'(e.we));
          check("ram_addr", 64'(ram_addr), 64'(e.addr));
          check("ram_wdata", 64'(ram_wdata), 64'(e.wdata));
        end
      end else begin
        check("ram_idle_zero", 64'({ram_we, ram_addr, ram_wdata}), 64'd0);
        if (ram_q.size() > 0 && ram_q[0].cyc <= cyc) begin
          e = ram_q.pop_front();
          fail_now("ram_missing_access");
        end
      end

      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          fail_now("resp_unexpected");
        end else begin
          r = resp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(r.cyc));
          check("resp_rd", 64'(resp_rd), 64'(r.rd));
          check("resp_wreg", 64'(resp_wreg), 64'(r.wreg));
          check("resp_data", 64'(resp_data), 64'(r.data));
          check("err_o", 64'(err_o), 64'(r.err));
          $display("resp  cyc=%0d rd=%0d wreg=%0b data=%08h err=%0b", cyc, resp_rd, resp_wreg, resp_data, err_o);
        end
      end else begin
        check("resp_idle_zero", 64'({err_o, resp_wreg, resp_rd, resp_data}), 64'd0);
        if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
          r = resp_q.pop_front();
          fail_now("resp_missing");
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    poke_en = 1'b1; poke_addr = a[9:0]; poke_data = d;
    ref_mem[a[9:0]] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Leaves req_valid high after the accept so a following call models EX
  // presenting the next request immediately (held while the unit is busy).
  task automatic do_req(input logic [3:0] op, input logic [31:0] addr, input logic [XLEN-1:0] wdata,
                        input logic [XLEN-1:0] result, input logic [4:0] rd, input logic wreg);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    req_result = result; req_rd = rd; req_wreg = wreg;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("accept_timeout");
      return;
    end
    model_request(cyc, op, addr, wdata, result, rd, wreg);
  endtask

  task automatic go_idle(input int cycles);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic drain();
    for (int t = 0; t < 200; t++) begin
      if (ram_q.size() == 0 && resp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    #2;
    if (ram_q.size() != 0 || resp_q.size() != 0) begin
      fail_now("drain_timeout");
      ram_q.delete();
      resp_q.delete();
    end
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 2) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 767));
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(10'(i));
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    req_result = '0; req_rd = '0; req_wreg = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_ram", 64'({ram_ce, ram_we, ram_addr, ram_wdata}), 64'd0);
    check("reset_resp", 64'({resp_valid, resp_wreg, resp_rd, resp_data}), 64'd0);
    check("reset_stall_err", 64'({stall_o, err_o}), 64'd0);
    busy_from = cyc; busy_to = cyc - 1;
    mon_en = 1'b1;

    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    poke(32'h203, 8'h80);
    poke(32'h010, 8'h34); poke(32'h011, 8'hF2);

    do_req(4'd5, 32'h0000_0100, 32'h0, 32'h0, 5'd3, 1'b1);          // LW
    do_req(4'd1, 32'h0000_0203, 32'h0, 32'h0, 5'd4, 1'b1);          // LB
    do_req(4'd2, 32'h0000_0203, 32'h0, 32'h0, 5'd5, 1'b1);          // LBU
    do_req(4'd3, 32'h0000_0010, 32'h0, 32'h0, 5'd6, 1'b1);          // LH
    do_req(4'd9, 32'h0000_0041, 32'hDEAD_BEEF, 32'h0, 5'd8, 1'b1);  // SH
    do_req(4'd5, 32'h0000_0040, 32'h0, 32'h0, 5'd9, 1'b1);          // LW
    do_req(4'd0, 32'h0, 32'h0, 32'hCAFE_BABE, 5'd7, 1'b1);          // NONE
    do_req(4'd0, 32'h0, 32'h0, 32'h1234_5678, 5'd10, 1'b0);         // held behind it
    do_req(4'd5, 32'hFFFF_FFFE, 32'h0, 32'h0, 5'd11, 1'b1);         // wrap
    do_req(4'd15, 32'h0, 32'h0, 32'h0BAD_F00D, 5'd12, 1'b1);        // illegal -> NONE
    go_idle(2);

    for (int t = 0; t < 120; t++) begin
      do_req(4'($urandom_range(0, 15)), rand_addr(), $urandom(), $urandom(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) go_idle($urandom_range(0, 4));
    end
    go_idle(1);
    drain();

    // Reset in the middle of a word load: access abandoned, no response.
    do_req(4'd5, 32'h0000_0120, 32'h0, 32'h0, 5'd13, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ram_q.delete();
    resp_q.delete();
    busy_from = cyc; busy_to = cyc - 1;
    @(negedge clk);
    check("midrst_ram_ce", 64'(ram_ce), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    repeat (6) @(posedge clk);

    do_req(4'd5, 32'h0000_0100, 32'h0, 32'h0, 5'd14, 1'b1);
    go_idle(1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
- Sequential load/store unit replacing the single-cycle memory stage.
- Accepts one request from EX via a valid/ready handshake and performs LB/LBU/LH/LHU/LW/SB/SH/SW as a sequence of byte transfers on an 8-bit RAM port with configurable read latency.
- Assembles little-endian data, sign- or zero-extends it, and returns a one-cycle result pulse to WB.
- Drives a stall to the pipeline while busy.

Parameters:
- XLEN, 32: register/data width; must be 32 or 64 (LD/SD enabled only when 64).
- ADDR_W, 32: RAM address width.
- RAM_LAT, 1: cycles from ram_ce&&!ram_we to valid ram_rdata; range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  EX presents request
- req_ready  out  1  unit can accept (IDLE only)
- req_op  in  4  lsu_op_t encoding (NONE, LB, LBU, LH, LHU, LW, LWU, LD, SB, SH, SW, SD)
- req_addr  in  ADDR_W  effective address
- req_wdata  in  XLEN  store data (rs2)
- req_result  in  XLEN  ALU result, forwarded for NONE
- req_rd  in  5  destination register
- req_wreg  in  1  destination write enable
- ram_ce  out  1  RAM access this cycle
- ram_we  out  1  1=write byte, 0=read byte
- ram_addr  out  ADDR_W  byte address
- ram_wdata  out  8  write byte
- ram_rdata  in  8  read byte, valid RAM_LAT cycles after issue
- resp_valid  out  1  one-cycle result pulse to WB
- resp_rd  out  5  destination register
- resp_wreg  out  1  write enable (0 for stores)
- resp_data  out  XLEN  extended load data or forwarded result
- stall_o  out  1  = req_valid && !req_ready
- err_o  out  1  misaligned pulse (feature only)

Behaviour:
- Reset: all outputs 0 except req_ready=1. State→IDLE, counters 0. Reset mid-operation abandons the access; no further RAM cycles are issued, and resp_valid is not asserted for the abandoned request.
- States: IDLE, ISSUE, DRAIN, RESP.
- IDLE:
  - Accept on req_valid&&req_ready and latch all request fields.
  - NONE → RESP.
  - Memory op → ISSUE with n = 1/2/4/8 by size, issue index i=0, capture index j=0.
- ISSUE:
  - Each cycle: ram_ce=1, ram_addr=addr+i (mod 2^ADDR_W), i++.
  - Store: ram_we=1, ram_wdata=wdata[8i+7:8i].
  - When i==n-1 is issued: store → RESP; load → DRAIN.
- Load capture: for every read issued at cycle t, ram_rdata at t+RAM_LAT goes into byte j of the assembly register, then j++. Reads are pipelined (one per cycle); capture runs during both ISSUE and DRAIN.
- DRAIN: ram_ce=0. When j==n → RESP.
- RESP (one cycle):
  - resp_valid=1 with resp_rd and resp_wreg from the request.
  - Stores force resp_wreg=0.
  - resp_data: sign-extend for LB/LH/LW(when XLEN=64); zero-extend for LBU/LHU/LWU; raw for LW(32)/LD; req_result for NONE; 0 for stores.
  - Then → IDLE.
- Latency:
  - NONE: resp at accept+1.
  - Store: accept+n+1.
  - Load: accept+n+RAM_LAT+1.
  - req_ready=1 again in the cycle after RESP. No back-to-back overlap.
- req_ready=1 only in IDLE. Requests while busy are held by EX (stall_o=1); the unit has no skid buffer.
- ram outputs 0 whenever ram_ce=0.
- Misaligned accesses (without the feature): performed byte-wise, including across word boundaries; no penalty.
- Address wrap: 0xFFFF_FFFF word access touches FFFFFFFF, 0, 1, 2.
- Illegal req_op: treated as NONE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a halfword/word/doubleword with addr not size-aligned issues no RAM cycles. The unit goes directly to RESP with resp_wreg=0, resp_data=0, err_o=1 for that cycle.
- Undefined: err_o tied 0; misaligned accesses are performed as above.

Decomposition:
- Package lsu_pkg:
  - lsu_op_t enum and state enum.
  - Function op_size(op) returning n.
  - Function op_is_signed(op).
  - Function op_is_store(op).
- Sub-module lsu_extend: combinational, takes the assembled bytes, size and signedness, and returns the XLEN result. Shared with future cache path.

Test Plan:
- LW addr 0x100, RAM bytes 78 56 34 12, RAM_LAT=1 → reads at 0x100..0x103; resp_data=0x12345678, resp_valid at accept+6.
- LB addr 0x203 byte 0x80 → 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x10 bytes 34 F2 → 0xFFFFF234.
- SH addr 0x41 wdata 0xDEADBEEF → writes EF@0x41, BE@0x42, resp_wreg=0 at accept+3; LW 0x40 then returns bytes unchanged except 0x41/0x42.
- NONE op, req_result 0xCAFEBABE rd 7 → resp at accept+1, data 0xCAFEBABE, resp_wreg follows request; second request during busy held, stall_o=1, accepted cycle after RESP.
- RAM_LAT=3 LW crossing 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1, correct assembly; rst asserted mid-ISSUE → ram_ce 0 next cycle, no resp_valid, req_ready=1.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x102 → no ram_ce, err_o=1 and resp_valid=1 at accept+1, resp_wreg=0.
